// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry and dump sequencer state encoding.
package regfile_pkg;
   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_COUNT  = 32;
   typedef enum logic [1:0] {IDLE, LOAD, SEND} dump_state_e;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: {addr,data,last} word stream with valid/ready handshake.
interface regfile_dump_reader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              valid;
   logic              ready;
   logic              last;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   modport master (output valid, last, addr, data, input ready);
   modport slave  (input valid, last, addr, data, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every register through one read port and streams {addr,data}.
// Optional XOR checksum of the dumped words when DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = REG_COUNT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic [ADDR_W-1:0]     rd_addr_o,
   input  logic [DATA_W-1:0]     rd_data_i,
   regfile_dump_reader_if.master out_if,
   output logic                  busy_o,
   output logic                  done_o
`ifdef DUMP_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]     checksum_o
`endif
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, chk_q, chk_d;
   logic              valid_q, valid_d, last_q, last_d, done_q, done_d;
   logic              acc;
   assign acc = valid_q & out_if.ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         chk_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         chk_q   <= chk_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (start_i ? LOAD : IDLE) :
                (state_q == LOAD) ? SEND :
                acc ? (last_q ? IDLE : LOAD) : SEND;
   end
   // Index returns to 0 on the final accept, so IDLE always reads address 0.
   always_comb begin
      idx_d   = (state_q == SEND && acc) ? (last_q ? '0 : idx_q + ADDR_W'(1)) : idx_q;
      addr_d  = (state_q == LOAD) ? idx_q : addr_q;
      data_d  = (state_q == LOAD) ? rd_data_i : data_q;
      last_d  = (state_q == LOAD) ? (idx_q == LAST_IDX) : (acc ? 1'b0 : last_q);
      valid_d = (state_q == LOAD) | (valid_q & ~acc);
      done_d  = (state_q == SEND) & acc & last_q;
      chk_d   = (state_q == IDLE && start_i) ? '0 : acc ? (chk_q ^ data_q) : chk_q;
   end
   assign rd_addr_o    = idx_q;
   assign out_if.valid = valid_q;
   assign out_if.last  = last_q;
   assign out_if.addr  = addr_q;
   assign out_if.data  = data_q;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
`ifdef DUMP_CHECKSUM_EN
   assign checksum_o   = chk_q;
`else
   logic unused_chk;
   assign unused_chk = ^chk_q;
`endif
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed scenarios against a behavioural register file.
// Checks the checksum output too when DUMP_CHECKSUM_EN is defined.
module tb_regfile_dump_reader;
   localparam int NR = 32;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy, done;
   logic [31:0] rf [NR];
   int          n_chk = 0;
   int          n_fail = 0;
`ifdef DUMP_CHECKSUM_EN
   logic [31:0] checksum;
`endif
   regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) dif ();
   regfile_dump_reader dut (
      .clk(clk),
      .rst(rst),
      .start_i(start),
      .rd_addr_o(rd_addr),
      .rd_data_i(rd_data),
      .out_if(dif),
      .busy_o(busy),
      .done_o(done)
`ifdef DUMP_CHECKSUM_EN
      ,
      .checksum_o(checksum)
`endif
   );
   assign rd_data = rf[rd_addr];
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic dump(input int stall_w, input int rs_w, input int wr_w, input logic [31:0] wr_v);
      logic [31:0] exp [NR];
      logic [31:0] x;
      int          w, cyc, stall;
      bit          fin;
      x = '0;
      for (int i = 0; i < NR; i++) begin
         exp[i] = rf[i];
         x ^= rf[i];
      end
      w = 0;
      cyc = 0;
      stall = (stall_w >= 0) ? 4 : 0;
      fin = 0;
      @(negedge clk);
      start = 1'b1;
      dif.ready = 1'b1;
      while (!fin && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         dif.ready = 1'b1;
         if (cyc == 1) begin
            check("busy_rise", busy, 1);
            check("lat_valid_lo", dif.valid, 0);
         end
         if (cyc == 2) check("lat_valid_hi", dif.valid, 1);
         if (dif.valid) begin
            check("addr", dif.addr, w);
            check("data", dif.data, exp[w]);
            check("last", dif.last, w == NR - 1);
            if (w == stall_w && stall > 0) begin
               dif.ready = 1'b0;
               stall--;
            end
            if (w == rs_w) start = 1'b1;
            if (w == wr_w) rf[w] = wr_v;
            if (dif.ready) w++;
         end
         if (done) begin
            fin = 1;
            check("done_cycle", cyc, 65 + ((stall_w >= 0) ? 4 : 0));
            check("word_count", w, NR);
`ifdef DUMP_CHECKSUM_EN
            check("checksum", checksum, x);
`endif
         end
      end
      if (!fin) check("done_timeout", 0, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after", busy, 0);
   endtask
   initial begin
      dif.ready = 1'b0;
      for (int i = 0; i < NR; i++) rf[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", dif.valid, 0);
      check("rst_addr", dif.addr, 0);
      check("rst_data", dif.data, 0);
      check("rst_last", dif.last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef DUMP_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      rst = 1'b0;
      dif.ready = 1'b1;
      rf[3] = 32'h01234567;
      rf[11] = 32'hABCDEF89;
      @(negedge clk);
      check("idle_ready_noeffect", dif.valid, 0);
      dump(-1, -1, -1, '0);
`ifdef DUMP_CHECKSUM_EN
      check("checksum_const", checksum, 32'hAAEEAAEE);
`endif
      dump(3, -1, -1, '0);
      dump(-1, 10, -1, '0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && !(dif.valid && dif.addr == 5'd7); i++) @(negedge clk);
      check("reach_word7", dif.addr, 7);
      rst = 1'b1;
      #1;
      check("abort_valid", dif.valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_rd_addr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      dump(-1, -1, -1, '0);
      dump(-1, -1, 5, 32'hDEADBEEF);
      check("rf5_written", rf[5], 32'hDEADBEEF);
      dump(-1, -1, -1, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
